// File: rtl/diff_drive_if.sv
// Interface for diff_drive_ctrl: steering/command inputs and the duty/status outputs.
// The master side is the command source (PID controller, bumper logic); the slave is the controller.
interface diff_drive_if #(
  parameter int DUTY_WIDTH   = 17,
  parameter int OFFSET_WIDTH = 18
);
  logic                           clk_en;
  logic                           kill;
  logic                           run_toggle;
  logic                           offset_valid;
  logic signed [OFFSET_WIDTH-1:0] offset_in;
  logic [DUTY_WIDTH-1:0]          duty_l;
  logic [DUTY_WIDTH-1:0]          duty_r;
  logic                           motor_en;
  logic [1:0]                     state;
  logic signed [OFFSET_WIDTH-1:0] offset_clamped;
  logic                           sample_valid;
  logic                           wdog_fault;

  modport master (
    output clk_en, kill, run_toggle, offset_valid, offset_in,
    input  duty_l, duty_r, motor_en, state, offset_clamped, sample_valid, wdog_fault
  );

  modport slave (
    input  clk_en, kill, run_toggle, offset_valid, offset_in,
    output duty_l, duty_r, motor_en, state, offset_clamped, sample_valid, wdog_fault
  );
endinterface

// File: rtl/diff_drive_ctrl.sv
// Differential-drive controller: run sequencer (IDLE/RAMP/RUN/BRAKE) with slew-limited
// ramp-up and braking, symmetric offset clamp and saturating left/right duty mix.
// Optional watchdog enabled by defining DIFF_DRIVE_WDOG_EN; without it wdog_fault is tied 0.
module diff_drive_ctrl #(
  parameter int DUTY_WIDTH   = 17,
  parameter int OFFSET_WIDTH = 18,
  parameter int BASE_DUTY    = 32768,
  parameter int MAX_OFFSET   = 16384,
  parameter int RAMP_STEP    = 1024,
  parameter int WDOG_TICKS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  diff_drive_if.slave bus
);

  // Mix width: wide enough for base +/- offset with sign and carry headroom.
  localparam int SW = ((DUTY_WIDTH > OFFSET_WIDTH) ? DUTY_WIDTH : OFFSET_WIDTH) + 2;

  localparam logic signed [OFFSET_WIDTH-1:0] OFF_MAX = OFFSET_WIDTH'(MAX_OFFSET);
  localparam logic signed [OFFSET_WIDTH-1:0] OFF_MIN = OFFSET_WIDTH'(-MAX_OFFSET);
  localparam logic signed [SW-1:0]           BASE_S  = SW'(BASE_DUTY);
  localparam logic signed [SW-1:0]           DMAX_S  = SW'({DUTY_WIDTH{1'b1}});
  localparam logic [DUTY_WIDTH-1:0]          BASE_D  = DUTY_WIDTH'(BASE_DUTY);
  localparam logic [DUTY_WIDTH:0]            STEP_E  = (DUTY_WIDTH+1)'(RAMP_STEP);

  // Elaboration-time parameter sanity checks.
  if (BASE_DUTY >= (2 ** DUTY_WIDTH)) begin : g_bad_base
    $error("BASE_DUTY must fit in DUTY_WIDTH bits");
  end
  if (MAX_OFFSET >= (2 ** (OFFSET_WIDTH - 1))) begin : g_bad_offset
    $error("MAX_OFFSET must be below 2^(OFFSET_WIDTH-1)");
  end
  if (RAMP_STEP <= 0 || WDOG_TICKS <= 0) begin : g_bad_step
    $error("RAMP_STEP and WDOG_TICKS must be positive");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [DUTY_WIDTH-1:0]          duty_l_q, duty_l_d;
  logic [DUTY_WIDTH-1:0]          duty_r_q, duty_r_d;
  logic                           motor_en_q, motor_en_d;
  logic                           sample_valid_q, sample_valid_d;
  logic signed [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic                           wdog_trip;

  // Offset held in RUN-mix width; sign-extended from the clamped register.
  logic signed [SW-1:0]   offset_ext;
  logic signed [SW-1:0]   sum_r, sum_l;
  logic [DUTY_WIDTH:0]    ramp_sum;

  assign offset_ext = SW'(offset_q);
  assign sum_r      = BASE_S + offset_ext;
  assign sum_l      = BASE_S - offset_ext;
  assign ramp_sum   = {1'b0, duty_l_q} + STEP_E;

  function automatic logic [DUTY_WIDTH-1:0] sat(input logic signed [SW-1:0] a);
    if (a[SW-1])
      return '0;
    else if (a > DMAX_S)
      return DMAX_S[DUTY_WIDTH-1:0];
    else
      return a[DUTY_WIDTH-1:0];
  endfunction

  function automatic logic [DUTY_WIDTH-1:0] brake_dec(input logic [DUTY_WIDTH-1:0] d);
    if ({1'b0, d} > STEP_E)
      return d - STEP_E[DUTY_WIDTH-1:0];
    else
      return '0;
  endfunction

  // Next-state, duty and enable logic: kill first, then run_toggle, then tick actions.
  always_comb begin
    state_d        = state_q;
    duty_l_d       = duty_l_q;
    duty_r_d       = duty_r_q;
    motor_en_d     = motor_en_q;
    sample_valid_d = 1'b0;
    offset_d       = offset_q;

    // Clamp before anything else touches the value, so the most negative input cannot overflow.
    if (bus.offset_valid) begin
      if (bus.offset_in > OFF_MAX)
        offset_d = OFF_MAX;
      else if (bus.offset_in < OFF_MIN)
        offset_d = OFF_MIN;
      else
        offset_d = bus.offset_in;
    end

    if (bus.kill) begin
      state_d    = ST_IDLE;
      duty_l_d   = '0;
      duty_r_d   = '0;
      motor_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_l_d   = '0;
          duty_r_d   = '0;
          motor_en_d = 1'b0;
          if (bus.run_toggle) begin
            state_d    = ST_RAMP;
            motor_en_d = 1'b1;
          end
        end
        ST_RAMP: begin
          if (bus.run_toggle) begin
            state_d = ST_BRAKE;
          end else if (bus.clk_en) begin
            if (ramp_sum >= {1'b0, BASE_D}) begin
              duty_l_d = BASE_D;
              duty_r_d = BASE_D;
              state_d  = ST_RUN;
            end else begin
              duty_l_d = ramp_sum[DUTY_WIDTH-1:0];
              duty_r_d = ramp_sum[DUTY_WIDTH-1:0];
            end
          end
        end
        ST_RUN: begin
          if (bus.run_toggle) begin
            state_d = ST_BRAKE;
          end else if (bus.clk_en) begin
            if (wdog_trip) begin
              state_d = ST_BRAKE;
            end else begin
              // Uses the offset registered before this cycle; a same-cycle offset waits a tick.
              duty_r_d       = sat(sum_r);
              duty_l_d       = sat(sum_l);
              sample_valid_d = 1'b1;
            end
          end
        end
        ST_BRAKE: begin
          if (bus.clk_en) begin
            duty_l_d = brake_dec(duty_l_q);
            duty_r_d = brake_dec(duty_r_q);
            if (duty_l_d == '0 && duty_r_d == '0) begin
              state_d    = ST_IDLE;
              motor_en_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Main state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      duty_l_q       <= '0;
      duty_r_q       <= '0;
      motor_en_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      offset_q       <= '0;
    end else begin
      state_q        <= state_d;
      duty_l_q       <= duty_l_d;
      duty_r_q       <= duty_r_d;
      motor_en_q     <= motor_en_d;
      sample_valid_q <= sample_valid_d;
      offset_q       <= offset_d;
    end
  end

`ifdef DIFF_DRIVE_WDOG_EN
  localparam int              WW         = $clog2(WDOG_TICKS + 1);
  localparam logic [WW-1:0]   WDOG_LAST  = WW'(WDOG_TICKS - 1);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_fault_q, wdog_fault_d;

  // Trip when this RUN tick would be the WDOG_TICKS-th without a fresh offset.
  assign wdog_trip = ~bus.offset_valid && (wdog_cnt_q == WDOG_LAST);

  // Watchdog count and sticky fault; fault clears only on a start accepted from IDLE.
  always_comb begin
    wdog_cnt_d   = wdog_cnt_q;
    wdog_fault_d = wdog_fault_q;
    if (state_d != ST_RUN || bus.offset_valid)
      wdog_cnt_d = '0;
    else if (state_q == ST_RUN && bus.clk_en)
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    if (!bus.kill && state_q == ST_IDLE && bus.run_toggle)
      wdog_fault_d = 1'b0;
    else if (!bus.kill && state_q == ST_RUN && !bus.run_toggle && bus.clk_en && wdog_trip)
      wdog_fault_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_q   <= '0;
      wdog_fault_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_fault_q <= wdog_fault_d;
    end
  end

  assign bus.wdog_fault = wdog_fault_q;
`else
  assign wdog_trip      = 1'b0;
  assign bus.wdog_fault = 1'b0;
`endif

  assign bus.duty_l         = duty_l_q;
  assign bus.duty_r         = duty_r_q;
  assign bus.motor_en       = motor_en_q;
  assign bus.state          = state_q;
  assign bus.offset_clamped = offset_q;
  assign bus.sample_valid   = sample_valid_q;

endmodule

// File: tb/tb_diff_drive_ctrl.sv
// Testbench for diff_drive_ctrl: directed stimulus, an integer-arithmetic reference model
// compared every cycle, plus hand-computed literal checks. Honours DIFF_DRIVE_WDOG_EN.
module tb_diff_drive_ctrl;
  localparam int DW   = 17;
  localparam int OW   = 18;
  localparam int BASE = 32768;
  localparam int MAXO = 16384;
  localparam int STEP = 1024;
  localparam int WD   = 8;
  localparam int DMAX = (1 << DW) - 1;
`ifdef DIFF_DRIVE_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  diff_drive_if #(.DUTY_WIDTH(DW), .OFFSET_WIDTH(OW)) bus ();

  diff_drive_ctrl #(
    .DUTY_WIDTH(DW), .OFFSET_WIDTH(OW), .BASE_DUTY(BASE),
    .MAX_OFFSET(MAXO), .RAMP_STEP(STEP), .WDOG_TICKS(WD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules in plain integers) ----------------
  int m_state, m_dl, m_dr, m_en, m_sv, m_off, m_wcnt, m_wf;

  function automatic int clampi(input int v);
    if (v > MAXO) return MAXO;
    if (v < -MAXO) return -MAXO;
    return v;
  endfunction

  function automatic int sati(input int v);
    if (v < 0) return 0;
    if (v > DMAX) return DMAX;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int old_off;
    if (reset) begin
      m_state = 0; m_dl = 0; m_dr = 0; m_en = 0; m_sv = 0; m_off = 0; m_wcnt = 0; m_wf = 0;
    end else begin
      old_off = m_off;
      m_sv = 0;
      if (bus.offset_valid) m_off = clampi(int'(bus.offset_in));
      if (bus.kill) begin
        m_state = 0; m_dl = 0; m_dr = 0; m_en = 0;
      end else begin
        case (m_state)
          0: if (bus.run_toggle) begin m_state = 1; m_en = 1; m_wf = 0; end
          1: if (bus.run_toggle) m_state = 3;
             else if (bus.clk_en) begin
               m_dl = (m_dl + STEP > BASE) ? BASE : m_dl + STEP;
               m_dr = m_dl;
               if (m_dl == BASE) m_state = 2;
             end
          2: if (bus.run_toggle) m_state = 3;
             else if (bus.clk_en) begin
               if (WDOG_ON && !bus.offset_valid && m_wcnt + 1 == WD) begin
                 m_state = 3; m_wf = 1;
               end else begin
                 m_dr = sati(BASE + old_off);
                 m_dl = sati(BASE - old_off);
                 m_sv = 1;
                 m_wcnt++;
               end
             end
          default: if (bus.clk_en) begin
               m_dl = (m_dl > STEP) ? m_dl - STEP : 0;
               m_dr = (m_dr > STEP) ? m_dr - STEP : 0;
               if (m_dl == 0 && m_dr == 0) begin m_state = 0; m_en = 0; end
             end
        endcase
      end
      if (m_state != 2 || bus.offset_valid) m_wcnt = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("state", bus.state, m_state);
    chk("duty_l", bus.duty_l, m_dl);
    chk("duty_r", bus.duty_r, m_dr);
    chk("motor_en", bus.motor_en, m_en);
    chk("sample_valid", bus.sample_valid, m_sv);
    chk("offset_clamped", bus.offset_clamped, m_off);
    chk("wdog_fault", bus.wdog_fault, m_wf);
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs at a negedge; return at the next negedge with outputs settled.
  task automatic cyc(input bit en, input bit tog, input bit k, input bit ov, input int off);
    bus.clk_en       = en;
    bus.run_toggle   = tog;
    bus.kill         = k;
    bus.offset_valid = ov;
    bus.offset_in    = OW'(off);
    @(negedge clk);
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    bus.clk_en = 1'b0; bus.run_toggle = 1'b0; bus.kill = 1'b0;
    bus.offset_valid = 1'b0; bus.offset_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_duty_l", bus.duty_l, 0);
    chk("rst_duty_r", bus.duty_r, 0);
    chk("rst_motor_en", bus.motor_en, 0);
    chk("rst_offset", bus.offset_clamped, 0);
    chk("rst_wdog", bus.wdog_fault, 0);
    reset = 1'b0;
    idle();

    // Start and ramp to cruise.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("start_state", bus.state, 1);
    chk("start_en", bus.motor_en, 1);
    chk("start_duty", bus.duty_l, 0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("ramp_duty_l", bus.duty_l, i * 1024);
      chk("ramp_duty_r", bus.duty_r, i * 1024);
      chk("ramp_state", bus.state, (i == 32) ? 2 : 1);
      idle();
    end

    // RUN mixing and clamping.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 20000);
    chk("clamp_pos", bus.offset_clamped, 16384);
    tick();
    chk("run_r_pos", bus.duty_r, 49152);
    chk("run_l_pos", bus.duty_l, 16384);
    chk("run_sv", bus.sample_valid, 1);
    idle();
    chk("run_sv_low", bus.sample_valid, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, -30000);
    chk("same_cyc_r", bus.duty_r, 49152);
    chk("clamp_neg", bus.offset_clamped, -16384);
    tick();
    chk("run_r_neg", bus.duty_r, 16384);
    chk("run_l_neg", bus.duty_l, 49152);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, -131072);
    chk("clamp_min", bus.offset_clamped, -16384);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 131071);
    chk("clamp_max", bus.offset_clamped, 16384);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 500);
    chk("pass_small", bus.offset_clamped, 500);
    tick();
    chk("run_r_small", bus.duty_r, 33268);
    chk("run_l_small", bus.duty_l, 32268);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 20000);
    tick();
    chk("run_r_again", bus.duty_r, 49152);

    // Stop: toggle wins over the tick in the same cycle, then brake per wheel.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("brake_state", bus.state, 3);
    chk("brake_hold_l", bus.duty_l, 16384);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("brake_ign_tog", bus.state, 3);
    for (int i = 1; i <= 48; i++) begin
      tick();
      if (i == 16) begin
        chk("brake16_l", bus.duty_l, 0);
        chk("brake16_r", bus.duty_r, 32768);
      end
      if (i == 47) begin
        chk("brake47_state", bus.state, 3);
        chk("brake47_r", bus.duty_r, 1024);
      end
      if (i == 48) begin
        chk("brake48_state", bus.state, 0);
        chk("brake48_en", bus.motor_en, 0);
      end
    end

    // Kill mid-ramp without a tick; toggle under kill ignored.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("kill_pre_r", bus.duty_l, 10240);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("kill_state", bus.state, 0);
    chk("kill_duty", bus.duty_r, 0);
    chk("kill_en", bus.motor_en, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("kill_tog_ign", bus.state, 0);
    idle();
    chk("after_kill", bus.state, 0);

    // Watchdog scenario: RUN with no fresh offsets.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 32; i++) tick();
    chk("wd_in_run", bus.state, 2);
    for (int i = 1; i <= 8; i++) tick();
    if (WDOG_ON) begin
      chk("wd_trip_state", bus.state, 3);
      chk("wd_fault", bus.wdog_fault, 1);
      for (int i = 0; i < 48; i++) tick();
      chk("wd_idle", bus.state, 0);
      chk("wd_sticky", bus.wdog_fault, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("wd_cleared", bus.wdog_fault, 0);
      chk("wd_restart", bus.state, 1);
    end else begin
      chk("nowd_state", bus.state, 2);
      chk("nowd_fault", bus.wdog_fault, 0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("final_kill", bus.state, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/diff_drive_ctrl.md
Name: diff_drive_ctrl

Overview:
Parametrised differential-drive controller. It takes a signed steering offset from a PID controller and a bumper-derived run/stop toggle, and produces registered left/right PWM duty words plus the motor enable. It adds a four-state run sequencer with slew-limited ramp-up and braking, symmetric offset clamping and a telemetry strobe. It sits between the PID controller and the two PWM generators, and replaces ad hoc duty/enable glue logic.

Parameters:
DUTY_WIDTH, 17, width of unsigned duty outputs
OFFSET_WIDTH, 18, width of signed offset input
BASE_DUTY, 32768, cruise duty for both wheels; must be < 2^DUTY_WIDTH
MAX_OFFSET, 16384, symmetric clamp magnitude; must be < 2^(OFFSET_WIDTH-1)
RAMP_STEP, 1024, duty change per update tick in RAMP and BRAKE; must be > 0
WDOG_TICKS, 8, watchdog limit in update ticks (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  update tick strobe, one clk wide
kill  in  1  level; forces stop, highest priority
run_toggle  in  1  one-clk pulse that requests start or stop
offset_valid  in  1  qualifies offset_in
offset_in  in  OFFSET_WIDTH  signed steering offset
duty_l  out  DUTY_WIDTH  left wheel duty
duty_r  out  DUTY_WIDTH  right wheel duty
motor_en  out  1  motor driver enable
state  out  2  IDLE=0, RAMP=1, RUN=2, BRAKE=3
offset_clamped  out  OFFSET_WIDTH  registered clamped offset
sample_valid  out  1  one-clk pulse each RUN duty update
wdog_fault  out  1  sticky watchdog flag; tied 0 without the optional feature

Behaviour:
- Reset values: all outputs are 0; state is IDLE.
- Offset register:
  - When offset_valid=1, offset_clamped <= clamp(offset_in, -MAX_OFFSET, +MAX_OFFSET). This register is independent of state.
  - Clamping is applied before any negation, so offset_in = -2^(OFFSET_WIDTH-1) is safe.
- Saturating add: sat(a) limits a to [0, 2^DUTY_WIDTH-1]. Compute in DUTY_WIDTH+2 bits, signed.
- Priority order, evaluated every clk: kill, then run_toggle, then tick actions.
- kill=1 in any state: next clk goes to IDLE with duties 0 and motor_en 0. This is not gated by clk_en. run_toggle is ignored while kill=1.
- IDLE:
  - duties 0, motor_en 0.
  - run_toggle -> RAMP on the next clk, motor_en 1, duties still 0.
- RAMP:
  - On each clk_en, ramp level r <= min(r+RAMP_STEP, BASE_DUTY).
  - duty_l = duty_r = r; offset is ignored.
  - When r reaches BASE_DUTY -> RUN in the same update.
  - run_toggle -> BRAKE.
- RUN:
  - On each clk_en: duty_r <= sat(BASE_DUTY + offset_clamped) and duty_l <= sat(BASE_DUTY - offset_clamped).
  - sample_valid pulses the clk after, coincident with the new duties.
  - run_toggle -> BRAKE.
- BRAKE:
  - On each clk_en, each duty <= max(duty - RAMP_STEP, 0), independently per wheel.
  - When both duties are 0 after an update -> IDLE and motor_en 0 on that same edge.
  - run_toggle is ignored in BRAKE.
- Latency: duty outputs change exactly one clk after the clk_en cycle that caused the update.
- run_toggle and clk_en in the same cycle: the transition wins; no tick action occurs in that cycle.
- offset_valid and clk_en in the same cycle: the RUN update uses the previously registered offset_clamped. The new value takes effect on the next tick.

Optional Feature:
- Macro: DIFF_DRIVE_WDOG_EN.
- Defined:
  - A watchdog counter clears on offset_valid and on leaving RUN.
  - It increments on each clk_en while in RUN.
  - When it reaches WDOG_TICKS: go to BRAKE and set wdog_fault=1.
  - wdog_fault is sticky and is cleared only by reset or by a run_toggle accepted in IDLE.
- Undefined: no counter exists and wdog_fault is tied 0.

Test Plan:
- Reset, then run_toggle and 32 clk_en ticks -> state RAMP, duties step 1024, 2048, ..., 32768; RUN is entered at tick 32; motor_en goes 1 the clk after the toggle.
- In RUN, offset_in=20000 with valid, then one tick -> offset_clamped=16384, duty_r=49152, duty_l=16384, one sample_valid pulse.
- In RUN, offset_in=-30000, then a tick -> duty_r=16384, duty_l=49152; offset -131072 -> clamp to -16384 with no overflow.
- From RUN with duty_r=49152 and duty_l=16384, run_toggle -> BRAKE; duty_l reaches 0 after 16 ticks; state goes IDLE and motor_en 0 after tick 48.
- kill asserted mid-RAMP (r=10240) with no clk_en -> next clk: IDLE, duties 0, motor_en 0; run_toggle while kill=1 is ignored.
- With DIFF_DRIVE_WDOG_EN defined, in RUN with no offset_valid for 8 ticks -> BRAKE and wdog_fault=1; it stays 1 through IDLE; the next accepted run_toggle clears it.
